// File: rtl/eq_stream_checker.sv
// Self-check for an equality comparator: it recomputes w1 == w2 for each accepted pair
// and counts matches and chk mismatches. It also latches the first failing vector.
module eq_stream_checker #(
  parameter int W     = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     w1,
  input  logic [W-1:0]     w2,
  input  logic             chk,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2*W:0]     first_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept;
  logic             last_accept;
  logic             start_ok;
  logic             v_q;
  logic [W-1:0]     w1_q, w2_q;
  logic             chk_q;
  logic             exp_eq;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((acc_cnt + CNT_ONE) == num_vec_q);
  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign exp_eq      = (w1_q == w2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = (num_vec == '0) ? DONE : RUN;
      RUN:        if (last_accept) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN);
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
    pass     = (state == DONE) && (err_cnt == '0);
  end

  // Stage 1 captures an accepted vector. Stage 2 scores it on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_vec_q <= '0;
      acc_cnt   <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      v_q       <= 1'b0;
      w1_q      <= '0;
      w2_q      <= '0;
      chk_q     <= 1'b0;
    end else begin
      v_q <= accept;
      if (accept) begin
        w1_q  <= w1;
        w2_q  <= w2;
        chk_q <= chk;
      end
      if (start_ok) begin
        num_vec_q <= num_vec;
        acc_cnt   <= '0;
        match_cnt <= '0;
        err_cnt   <= '0;
        first_err <= '0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + CNT_ONE;
        if (v_q) begin
          if (exp_eq && (match_cnt != CNT_MAX)) match_cnt <= match_cnt + CNT_ONE;
          if (chk_q != exp_eq) begin
            if (err_cnt == '0) first_err <= {w1_q, w2_q, chk_q};
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eq_stream_checker.sv
// Directed bench for eq_stream_checker. Expected values are hand-computed from the
// vector tables in each step.
module tb_eq_stream_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vec;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  w1;
  logic [1:0]  w2;
  logic        chk;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] match_cnt;
  logic [15:0] err_cnt;
  logic [4:0]  first_err;

  int checks = 0;
  int errors = 0;

  eq_stream_checker #(.W(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w1        (w1),
    .w2        (w2),
    .chk       (chk),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .match_cnt (match_cnt),
    .err_cnt   (err_cnt),
    .first_err (first_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] nv, input logic v,
                               input logic [1:0] a, input logic [1:0] b, input logic c);
    start    = s;
    num_vec  = nv;
    in_valid = v;
    w1       = a;
    w2       = b;
    chk      = c;
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s.%s: observed %0h expected %0h", tag, field, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic e_ready, input logic e_busy,
                             input logic e_done, input logic e_pass, input logic [15:0] e_match,
                             input logic [15:0] e_err, input logic [4:0] e_first);
    cmp(tag, "in_ready",  32'(in_ready),  32'(e_ready));
    cmp(tag, "busy",      32'(busy),      32'(e_busy));
    cmp(tag, "done",      32'(done),      32'(e_done));
    cmp(tag, "pass",      32'(pass),      32'(e_pass));
    cmp(tag, "match_cnt", 32'(match_cnt), 32'(e_match));
    cmp(tag, "err_cnt",   32'(err_cnt),   32'(e_err));
    cmp(tag, "first_err", 32'(first_err), 32'(e_first));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    #2;
    checkOutput("reset", 0, 0, 0, 0, 16'd0, 16'd0, 5'b00000);
    #10;
    rst_n = 1'b1;
    tick();

    // Run 1: four correct vectors back-to-back
    applyStimulus(1'b1, 16'd4, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    checkOutput("t1.run", 1, 1, 0, 0, 16'd0, 16'd0, 5'b00000);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd1, 2'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd2, 2'd3, 1'b0);
    tick();
    checkOutput("t1.mid", 1, 1, 0, 0, 16'd1, 16'd0, 5'b00000);
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd3, 2'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    checkOutput("t1.drain", 0, 1, 0, 0, 16'd1, 16'd0, 5'b00000);
    tick();
    checkOutput("t1.done", 0, 0, 1, 1, 16'd2, 16'd0, 5'b00000);

    // Run 2: restart from DONE with two wrong chk values
    applyStimulus(1'b1, 16'd4, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd0, 2'd1, 1'b1);
    checkOutput("t2.run", 1, 1, 0, 0, 16'd0, 16'd0, 5'b00000);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd1, 2'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd2, 2'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd3, 2'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    checkOutput("t2.done", 0, 0, 1, 0, 16'd2, 16'd2, 5'b00011);

    // Run 3: three vectors with in_valid gaps, then extra inputs in DRAIN/DONE
    applyStimulus(1'b1, 16'd3, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd1, 2'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd2, 2'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd0, 2'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd1, 2'd1, 1'b0);
    checkOutput("t3.drain", 0, 1, 0, 0, 16'd2, 16'd0, 5'b00000);
    tick();
    checkOutput("t3.done", 0, 0, 1, 1, 16'd2, 16'd0, 5'b00000);
    tick();
    checkOutput("t3.hold", 0, 0, 1, 1, 16'd2, 16'd0, 5'b00000);

    // Run 4: zero-length run finishes on the next cycle
    applyStimulus(1'b1, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    checkOutput("t4.zero", 0, 0, 1, 1, 16'd0, 16'd0, 5'b00000);

    // Run 5: start ignored in RUN, then asynchronous reset mid-run
    applyStimulus(1'b1, 16'd4, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd1, 2'd1, 1'b1);
    tick();
    applyStimulus(1'b1, 16'd0, 1'b1, 2'd2, 2'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    checkOutput("t5.ignore", 1, 1, 0, 0, 16'd1, 16'd1, 5'b10001);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5.reset", 0, 0, 0, 0, 16'd0, 16'd0, 5'b00000);
    #2;
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 16'd4, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd0, 2'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd1, 2'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd3, 2'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 2'd2, 2'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    checkOutput("t5.rerun", 0, 0, 1, 1, 16'd2, 16'd0, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
